// File: rtl/multi_cpu_if.sv
// Memory/IO bus between the multi-cycle CPU (master) and the memory/IO system (slave).
// One shared port carries both instruction fetches and data accesses.
interface multi_cpu_if;
  logic [31:0] Data_in;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic        mem_w;
  logic        CPU_MIO;
  logic        MIO_ready;

  modport master (
    input  Data_in,
    input  MIO_ready,
    output Addr_out,
    output Data_out,
    output mem_w,
    output CPU_MIO
  );

  modport slave (
    output Data_in,
    output MIO_ready,
    input  Addr_out,
    input  Data_out,
    input  mem_w,
    input  CPU_MIO
  );
endinterface

// File: rtl/multi_cpu.sv
// Multi-cycle 32-bit MIPS-subset core sharing one instruction/data memory port.
// Define MCPU_INT_EN to build the external interrupt (IE/EPC, INT_ENTRY, ERET).
module multi_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT,
  multi_cpu_if.master bus,
  output logic [31:0] PC_out,
  output logic [31:0] inst_out,
  output logic [4:0]  state
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

`ifdef MCPU_INT_EN
  localparam logic [5:0]      OP_COP0    = 6'h10;
  localparam logic [XLEN-1:0] ERET_WORD  = 32'h4200_0018;
  localparam logic [XLEN-1:0] INT_VECTOR = 32'h0000_0004;
`endif

  typedef enum logic [4:0] {
    S_IF        = 5'd0,
    S_ID        = 5'd1,
    S_EX_R      = 5'd2,
    S_EX_MEM    = 5'd3,
    S_MEM_RD    = 5'd4,
    S_MEM_WR    = 5'd5,
    S_WB_LW     = 5'd6,
    S_WB_R      = 5'd7,
    S_EX_BR     = 5'd8,
    S_EX_J      = 5'd9,
    S_EX_JAL    = 5'd10,
    S_EX_I      = 5'd11,
    S_WB_I      = 5'd12,
    S_EX_JR     = 5'd13,
    S_ERET      = 5'd14,
    S_INT_ENTRY = 5'd15
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_ir;
  logic [XLEN-1:0]   r_alu_out;
  logic [XLEN-1:0]   r_mdr;
  logic [XLEN-1:0]   r_rf [NREG];

`ifdef MCPU_INT_EN
  logic              r_ie;
  logic [XLEN-1:0]   r_epc;
`else
  logic              w_int_unused;
  assign w_int_unused = INT;
`endif

  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [4:0]        w_shamt;
  logic [5:0]        w_funct;
  logic [15:0]       w_imm;
  logic [XLEN-1:0]   w_sext;
  logic [XLEN-1:0]   w_zext;
  logic [XLEN-1:0]   w_rs_val;
  logic [XLEN-1:0]   w_rt_val;
  logic [XLEN-1:0]   w_alu_res;
  logic [XLEN-1:0]   w_br_target;
  logic [XLEN-1:0]   w_j_target;
  logic              w_br_taken;
  logic              w_rf_we;
  logic [4:0]        w_rf_wa;
  logic [XLEN-1:0]   w_rf_wd;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_shamt  = r_ir[10:6];
  assign w_funct  = r_ir[5:0];
  assign w_imm    = r_ir[15:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'h0000, w_imm};

  // $0 is never written, so its storage stays at the reset value of zero
  assign w_rs_val = r_rf[w_rs];
  assign w_rt_val = r_rf[w_rt];

  // PC already holds PC+4 by the time any EX state runs
  assign w_br_target = r_pc + {w_sext[29:0], 2'b00};
  assign w_j_target  = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_br_taken  = (w_op == OP_BEQ) ? (w_rs_val == w_rt_val) : (w_rs_val != w_rt_val);

  assign bus.Data_out = w_rt_val;
  assign PC_out       = r_pc;
  assign inst_out     = r_ir;
  assign state        = r_state;

  // ALU: R-type, immediate and address calculation share one result path
  always_comb begin
    w_alu_res = '0;
    case (r_state)
      S_EX_R: begin
        case (w_funct)
          FN_ADD:  w_alu_res = w_rs_val + w_rt_val;
          FN_SUB:  w_alu_res = w_rs_val - w_rt_val;
          FN_AND:  w_alu_res = w_rs_val & w_rt_val;
          FN_OR:   w_alu_res = w_rs_val | w_rt_val;
          FN_XOR:  w_alu_res = w_rs_val ^ w_rt_val;
          FN_NOR:  w_alu_res = ~(w_rs_val | w_rt_val);
          FN_SLT:  w_alu_res = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
          FN_SLL:  w_alu_res = w_rt_val << w_shamt;
          FN_SRL:  w_alu_res = w_rt_val >> w_shamt;
          default: w_alu_res = '0;
        endcase
      end
      S_EX_I: begin
        case (w_op)
          OP_ADDI: w_alu_res = w_rs_val + w_sext;
          OP_ANDI: w_alu_res = w_rs_val & w_zext;
          OP_ORI:  w_alu_res = w_rs_val | w_zext;
          OP_XORI: w_alu_res = w_rs_val ^ w_zext;
          OP_SLTI: w_alu_res = {31'd0, $signed(w_rs_val) < $signed(w_sext)};
          OP_LUI:  w_alu_res = {w_imm, 16'h0000};
          default: w_alu_res = '0;
        endcase
      end
      S_EX_MEM: w_alu_res = w_rs_val + w_sext;
      default:  w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, bus strobes and register-file write port
  always_comb begin
    w_next       = r_state;
    w_rf_we      = 1'b0;
    w_rf_wa      = '0;
    w_rf_wd      = '0;
    bus.mem_w    = 1'b0;
    bus.CPU_MIO  = 1'b0;
    bus.Addr_out = r_alu_out;
    case (r_state)
      S_IF: begin
        bus.CPU_MIO  = 1'b1;
        bus.Addr_out = r_pc;
        if (bus.MIO_ready) w_next = S_ID;
      end
      S_ID: begin
        w_next = S_IF;
        case (w_op)
          OP_RTYPE: begin
            case (w_funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
              FN_NOR, FN_SLT, FN_SLL, FN_SRL: w_next = S_EX_R;
              FN_JR, FN_JALR:                 w_next = S_EX_JR;
              default:                        w_next = S_IF;
            endcase
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: w_next = S_EX_I;
          OP_LW, OP_SW:   w_next = S_EX_MEM;
          OP_BEQ, OP_BNE: w_next = S_EX_BR;
          OP_J:           w_next = S_EX_J;
          OP_JAL:         w_next = S_EX_JAL;
`ifdef MCPU_INT_EN
          OP_COP0:        if (r_ir == ERET_WORD) w_next = S_ERET;
`endif
          default:        w_next = S_IF;
        endcase
      end
      S_EX_R:   w_next = S_WB_R;
      S_EX_I:   w_next = S_WB_I;
      S_EX_MEM: w_next = (w_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        bus.CPU_MIO = 1'b1;
        if (bus.MIO_ready) w_next = S_WB_LW;
      end
      S_MEM_WR: begin
        bus.CPU_MIO = 1'b1;
        bus.mem_w   = 1'b1;
        if (bus.MIO_ready) w_next = S_IF;
      end
      S_WB_LW: begin
        w_rf_we = 1'b1;
        w_rf_wa = w_rt;
        w_rf_wd = r_mdr;
        w_next  = S_IF;
      end
      S_WB_R: begin
        w_rf_we = 1'b1;
        w_rf_wa = w_rd;
        w_rf_wd = r_alu_out;
        w_next  = S_IF;
      end
      S_WB_I: begin
        w_rf_we = 1'b1;
        w_rf_wa = w_rt;
        w_rf_wd = r_alu_out;
        w_next  = S_IF;
      end
      S_EX_JAL: begin
        w_rf_we = 1'b1;
        w_rf_wa = 5'd31;
        w_rf_wd = r_pc;
        w_next  = S_IF;
      end
      S_EX_JR: begin
        w_rf_we = (w_funct == FN_JALR);
        w_rf_wa = w_rd;
        w_rf_wd = r_pc;
        w_next  = S_IF;
      end
      default: w_next = S_IF;
    endcase
`ifdef MCPU_INT_EN
    // Interrupts are taken only on the way back to IF; ERET re-enables IE in the same step
    if (w_next == S_IF && r_state != S_IF && r_state != S_INT_ENTRY &&
        INT && (r_ie || r_state == S_ERET)) begin
      w_next = S_INT_ENTRY;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      case (r_state)
        S_IF: begin
          if (bus.MIO_ready) begin
            r_ir <= bus.Data_in;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_EX_R, S_EX_I, S_EX_MEM: r_alu_out <= w_alu_res;
        S_MEM_RD:         if (bus.MIO_ready) r_mdr <= bus.Data_in;
        S_EX_BR:          if (w_br_taken) r_pc <= w_br_target;
        S_EX_J, S_EX_JAL: r_pc <= w_j_target;
        S_EX_JR:          r_pc <= w_rs_val;
`ifdef MCPU_INT_EN
        S_ERET:           r_pc <= r_epc;
        S_INT_ENTRY:      r_pc <= INT_VECTOR;
`endif
        default: ;
      endcase
    end
  end

`ifdef MCPU_INT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie  <= 1'b1;
      r_epc <= '0;
    end else if (r_state == S_INT_ENTRY) begin
      r_epc <= r_pc;
      r_ie  <= 1'b0;
    end else if (r_state == S_ERET) begin
      r_ie  <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_rf_we && w_rf_wa != 5'd0) begin
      r_rf[w_rf_wa] <= w_rf_wd;
    end
  end

endmodule

// File: tb/tb_multi_cpu.sv
// Self-checking bench for multi_cpu: state/PC sequencing, stores scored against a queue.
// Interrupt scenarios follow MCPU_INT_EN when it is defined.
module tb_multi_cpu;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        INT;
  logic [31:0] PC_out;
  logic [31:0] inst_out;
  logic [4:0]  state;
  logic        force_en;
  logic [31:0] force_val;
  logic [31:0] mem [64];
  store_t      sb_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          stall_armed;
  bit          stall_done;

  always #5 clk = ~clk;

  multi_cpu_if bus ();

  assign bus.Data_in = force_en ? force_val : mem[bus.Addr_out[7:2]];

  multi_cpu dut (
    .clk      (clk),
    .reset    (reset),
    .INT      (INT),
    .bus      (bus),
    .PC_out   (PC_out),
    .inst_out (inst_out),
    .state    (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock: score any store completing on this edge, then sample 1 time unit after the edge
  task automatic step();
    store_t e;
    if (!reset && bus.mem_w && bus.MIO_ready) begin
      if (sb_q.size() == 0) begin
        check("store_expected", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("store_addr", bus.Addr_out, e.addr);
        check("store_data", bus.Data_out, e.data);
      end
      mem[bus.Addr_out[7:2]] = bus.Data_out;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.MIO_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    sb_q.push_back({a, d});
  endtask

  // Run until every expected store has been seen; a lw found in MEM_RD gets a 3-cycle stall
  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      if (stall_armed && state == 5'd4) begin
        stall_armed = 1'b0;
        bus.MIO_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check("stall_state", 32'(state), 32'd4);
          check("stall_addr", bus.Addr_out, 32'h80);
        end
        check("stall_pc", PC_out, 32'h40);
        check("stall_mem_w", 32'(bus.mem_w), 32'd0);
        bus.MIO_ready = 1'b1;
        step();
        check("lw_wb_state", 32'(state), 32'd6);
        step();
        check("lw_done_state", 32'(state), 32'd0);
        stall_done = 1'b1;
        n += 5;
      end else begin
        step();
        n++;
      end
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic load_main();
    logic [31:0] prog [27];
    prog = '{32'h20010005, 32'hAC010080, 32'h2002FFFD, 32'h00221820, 32'hAC030084,
             32'h00412022, 32'hAC040088, 32'h34058001, 32'h3C061234, 32'h00A63825,
             32'hAC07008C, 32'h0041402A, 32'h00014900, 32'h01095020, 32'hAC0A0090,
             32'h8C0B0080, 32'h11610001, 32'hAC000094, 32'h15610001, 32'h396C000F,
             32'hAC0C0094, 32'h0C000018, 32'hAC1F0098, 32'h08000017, 32'hAC1F009C,
             32'hFFFFFFFF, 32'h03E00008};
    clear_mem();
    for (int i = 0; i < 27; i++) mem[i] = prog[i];
  endtask

  initial begin
    int n;
    force_en      = 1'b1;
    force_val     = 32'h42000018;
    INT           = 1'b0;
    reset         = 1'b1;
    stall_armed   = 1'b0;
    stall_done    = 1'b0;
    bus.MIO_ready = 1'b1;
    clear_mem();

    // Reset state
    repeat (2) step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", PC_out, 32'h0);
    check("rst_mem_w", 32'(bus.mem_w), 32'd0);
    check("rst_cpu_mio", 32'(bus.CPU_MIO), 32'd1);
    check("rst_addr", bus.Addr_out, 32'h0);
    check("rst_ir", inst_out, 32'h0);
    reset = 1'b0;

    // ERET word held on the bus
    step();
    check("eret_id_state", 32'(state), 32'd1);
    check("eret_id_pc", PC_out, 32'h4);
    check("eret_ir", inst_out, 32'h42000018);
    step();
`ifdef MCPU_INT_EN
    check("eret_state", 32'(state), 32'd14);
    step();
    check("eret_ret_state", 32'(state), 32'd0);
    check("eret_ret_pc", PC_out, 32'h0);
`else
    check("eret_undec_state", 32'(state), 32'd0);
    check("eret_undec_pc", PC_out, 32'h4);
    step();
    check("eret_undec_id", 32'(state), 32'd1);
    check("eret_undec_pc2", PC_out, 32'h8);
`endif

    // beq $0,$0,-1 loops on PC 0 in 3 cycles; INT must be ignored without the feature
    force_val = 32'h1000FFFF;
`ifndef MCPU_INT_EN
    INT = 1'b1;
`endif
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      step();
      check("beq_id_state", 32'(state), 32'd1);
      check("beq_id_pc", PC_out, 32'h4);
      step();
      check("beq_ex_state", 32'(state), 32'd8);
      step();
      check("beq_if_state", 32'(state), 32'd0);
      check("beq_loop_pc", PC_out, 32'h0);
    end
    INT = 1'b0;

    // Program from memory: ALU ops, lw with stall, branches, jal/jr, undecoded word
    force_en = 1'b0;
    load_main();
    push(32'h80, 32'h5);
    push(32'h84, 32'h2);
    push(32'h88, 32'hFFFFFFF8);
    push(32'h8C, 32'h12348001);
    push(32'h90, 32'h51);
    push(32'h94, 32'hA);
    push(32'h9C, 32'h58);
    push(32'h98, 32'h58);
    stall_armed = 1'b1;
    apply_reset();
    drain(600);
    check("stall_seen", 32'(stall_done), 32'd1);
    repeat (30) step();

`ifdef MCPU_INT_EN
    // INT during an R-type at 0x10, handler at 0x4 stores then ERETs back to 0x14
    clear_mem();
    mem[0] = 32'h08000004;
    mem[1] = 32'h20140007;
    mem[2] = 32'hAC1400A0;
    mem[3] = 32'h42000018;
    mem[4] = 32'h00000820;
    mem[5] = 32'hAC1400A4;
    mem[6] = 32'h08000006;
    push(32'hA0, 32'h7);
    push(32'hA4, 32'h7);
    apply_reset();
    n = 0;
    while (!(state == 5'd2 && PC_out == 32'h14) && n < 50) begin
      step();
      n++;
    end
    check("int_reach_ex_r", 32'(state), 32'd2);
    INT = 1'b1;
    step();
    check("int_wb_r_state", 32'(state), 32'd7);
    step();
    check("int_entry_state", 32'(state), 32'd15);
    INT = 1'b0;
    step();
    check("int_vec_state", 32'(state), 32'd0);
    check("int_vec_pc", PC_out, 32'h4);
    n = 0;
    while (state != 5'd14 && n < 50) begin
      step();
      n++;
    end
    check("int_eret_state", 32'(state), 32'd14);
    step();
    check("int_ret_pc", PC_out, 32'h14);
    check("int_ret_state", 32'(state), 32'd0);
    drain(100);
`else
    n = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
